// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_ctrl_pkg;

    localparam int BYTE_WIDTH  = 8;
    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/boot_word_asm.sv
// Big-endian 4-byte shift assembler; one byte per shift_en, word valid the cycle after full.
// full flags the cycle that shifts in the last byte, so the caller can act on the same edge.
module boot_word_asm
    import imem_boot_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [BYTE_WIDTH-1:0]  byte_in,
    output logic [INSTR_WIDTH-1:0] word_out,
    output logic                   full
);

    logic [1:0]             idx;
    logic [INSTR_WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (shift_en) begin
            word_q <= {word_q[INSTR_WIDTH-BYTE_WIDTH-1:0], byte_in};
            idx    <= idx + 2'd1;
        end
    end

    assign word_out = word_q;
    assign full     = shift_en && (idx == 2'd3);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Arbitrates the instruction-memory port between a byte-stream boot loader and CPU fetch.
// Last byte at t -> write t+1, done t+2, fetch released t+3; fetch is stalled with NOP while loading.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int                          INSTR_ADDR_WIDTH = 32,
    parameter int                          CNT_WIDTH        = 10,
    parameter logic [INSTR_ADDR_WIDTH-1:0] BOOT_BASE        = '0,
    parameter bit                          BOOT_ON_RESET    = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_boot_req,
    input  logic                        i_byte_valid,
    input  logic [BYTE_WIDTH-1:0]       i_byte_data,
    output logic                        o_byte_ready,
    input  logic [INSTR_ADDR_WIDTH-1:0] i_fetch_address,
    output logic [INSTR_WIDTH-1:0]      o_fetch_instruction,
    output logic                        o_fetch_stall,
    output logic [INSTR_ADDR_WIDTH-1:0] o_mem_address,
    output logic [INSTR_WIDTH-1:0]      o_mem_wdata,
    output logic                        o_mem_we,
    input  logic [INSTR_WIDTH-1:0]      i_mem_rdata,
    output logic                        o_boot_done,
    output logic                        o_boot_err
);

    localparam logic [31:0]        MAX_WORDS = 32'(1) << CNT_WIDTH;
    localparam logic [CNT_WIDTH:0] CNT_ONE   = 1;

    state_e                 state_q, state_n;
    logic [CNT_WIDTH:0]     word_cnt, len_q;
    logic                   boot_err_q;
    logic                   shift_en, asm_full, start, len_err, write_last;
    logic [INSTR_WIDTH-1:0] asm_word, len_next;

    assign o_byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign shift_en     = i_byte_valid && o_byte_ready;
    assign start        = (state_q == S_RUN) && i_boot_req;
    // Length decision is taken on the edge that accepts its last byte.
    assign len_next     = {asm_word[INSTR_WIDTH-BYTE_WIDTH-1:0], i_byte_data};
    assign len_err      = (state_q == S_LEN) && asm_full && (len_next > MAX_WORDS);
    assign write_last   = (word_cnt + CNT_ONE) == len_q;

    boot_word_asm u_asm (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (start),
        .shift_en (shift_en),
        .byte_in  (i_byte_data),
        .word_out (asm_word),
        .full     (asm_full)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= BOOT_ON_RESET ? S_LEN : S_RUN;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_RUN:   if (i_boot_req) state_n = S_LEN;
            S_LEN: begin
                if (asm_full) begin
                    if (len_next == '0)          state_n = S_DONE;
                    else if (len_next > MAX_WORDS) state_n = S_RUN;
                    else                         state_n = S_DATA;
                end
            end
            S_DATA:  if (asm_full) state_n = S_WRITE;
            S_WRITE: state_n = write_last ? S_DONE : S_DATA;
            S_DONE:  state_n = S_RUN;
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            word_cnt   <= '0;
            len_q      <= '0;
            boot_err_q <= 1'b0;
        end else begin
            if (start) begin
                word_cnt   <= '0;
                boot_err_q <= 1'b0;
            end
            if ((state_q == S_LEN) && asm_full) len_q <= len_next[CNT_WIDTH:0];
            if (len_err) boot_err_q <= 1'b1;
            if (state_q == S_WRITE) word_cnt <= word_cnt + CNT_ONE;
        end
    end

    assign o_mem_we            = (state_q == S_WRITE);
    assign o_fetch_stall       = (state_q != S_RUN);
    assign o_boot_done         = (state_q == S_DONE);
    assign o_boot_err          = boot_err_q;
    assign o_mem_wdata         = asm_word;
    assign o_fetch_instruction = (state_q == S_RUN) ? i_mem_rdata : NOP_INSTR;
    assign o_mem_address       = (state_q == S_RUN) ? i_fetch_address
                               : BOOT_BASE + INSTR_ADDR_WIDTH'({word_cnt, 2'b00});

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: per-cycle vector table plus multi-cycle load sequences.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_req = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [31:0] fetch_address = 32'h0;

    logic        byte_ready, fetch_stall, mem_we, boot_done, boot_err;
    logic [31:0] fetch_instruction, mem_address, mem_wdata, mem_rdata;

    logic        r_ready, r_stall, r_we, r_done, r_err;
    logic [31:0] r_instr, r_addr, r_wdata;

    logic [31:0] mem [0:63];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    imem_boot_ctrl #(.INSTR_ADDR_WIDTH(32), .CNT_WIDTH(4), .BOOT_BASE(32'h0), .BOOT_ON_RESET(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_boot_req(boot_req),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data), .o_byte_ready(byte_ready),
        .i_fetch_address(fetch_address), .o_fetch_instruction(fetch_instruction),
        .o_fetch_stall(fetch_stall), .o_mem_address(mem_address), .o_mem_wdata(mem_wdata),
        .o_mem_we(mem_we), .i_mem_rdata(mem_rdata), .o_boot_done(boot_done), .o_boot_err(boot_err)
    );

    imem_boot_ctrl #(.INSTR_ADDR_WIDTH(32), .CNT_WIDTH(10), .BOOT_BASE(32'h100), .BOOT_ON_RESET(1'b0)) dut_run (
        .i_clk(clk), .i_rst_n(rst_n), .i_boot_req(boot_req),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data), .o_byte_ready(r_ready),
        .i_fetch_address(fetch_address), .o_fetch_instruction(r_instr),
        .o_fetch_stall(r_stall), .o_mem_address(r_addr), .o_mem_wdata(r_wdata),
        .o_mem_we(r_we), .i_mem_rdata(32'hCAFE_F00D), .o_boot_done(r_done), .o_boot_err(r_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_address[7:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // The stream must never be accepted while a word is being written.
    always @(negedge clk) begin
        #2;
        if (mem_we) chk("ready_in_write", byte_ready, 1'b0);
    end

    typedef struct {
        logic        req;
        logic        valid;
        logic [7:0]  data;
        logic [31:0] fetch;
        logic        rdy;
        logic        we;
        logic        stall;
        logic        done;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic valid, input logic [7:0] data,
                                input logic [31:0] fetch, input logic rdy, input logic we,
                                input logic stall, input logic done, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] wdata);
        vec_t v;
        v.req = req; v.valid = valid; v.data = data; v.fetch = fetch;
        v.rdy = rdy; v.we = we; v.stall = stall; v.done = done;
        v.addr = addr; v.instr = instr; v.wdata = wdata;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit req_mid);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            boot_req   = req_mid && (g == 0);
            @(negedge clk);
        end
        boot_req   = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        #1;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept: byte %0h never accepted (ready %0b, required 1)", b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input bit req_mid);
        for (int k = 0; k < 4; k++) begin
            int gap;
            logic [31:0] sh;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (req_mid && k == 1 && gap == 0) gap = 1;
            sh = w << (8 * k);
            send_byte(sh[31:24], gap, req_mid && k == 1);
        end
    endtask

    task automatic start_boot();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        #1;
        while (!boot_done && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_done_lat"}, n, 1);
        @(negedge clk);
        #1;
        chk({name, "_unstall"}, {fetch_stall, boot_done}, 2'b00);
    endtask

    vec_t tbl [23];
    int   wr0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Image 00000002 DEADBEEF 01234567 straight out of reset, then N=0 from S_RUN.
        tbl[0]  = mk(0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 8'h02, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 8'hDE, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'hAD, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 8'hBE, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 8'hEF, 0, 1, 0, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 8'h01, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF);
        tbl[9]  = mk(0, 1, 8'h01, 0, 1, 0, 1, 0, 4, 0, 0);
        tbl[10] = mk(0, 1, 8'h23, 0, 1, 0, 1, 0, 4, 0, 0);
        tbl[11] = mk(0, 1, 8'h45, 0, 1, 0, 1, 0, 4, 0, 0);
        tbl[12] = mk(0, 1, 8'h67, 0, 1, 0, 1, 0, 4, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 1, 1, 0, 4, 0, 32'h0123_4567);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 8, 0, 0);
        tbl[15] = mk(0, 0, 8'h00, 4, 0, 0, 0, 0, 4, 32'h0123_4567, 0);
        tbl[16] = mk(1, 1, 8'hAA, 6, 0, 0, 0, 0, 6, 32'h0123_4567, 0);
        tbl[17] = mk(0, 1, 8'h00, 6, 1, 0, 1, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 8'h00, 6, 1, 0, 1, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 8'h00, 6, 1, 0, 1, 0, 0, 0, 0);
        tbl[20] = mk(0, 1, 8'h00, 6, 1, 0, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 8'h00, 6, 0, 0, 1, 1, 0, 0, 0);
        tbl[22] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);

        fetch_address = 32'h1236;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_boot_state", {byte_ready, fetch_stall, boot_done, boot_err, mem_we, mem_address},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        chk("rst_nop", fetch_instruction, 32'h0);
        chk("rst_run_state", {r_ready, r_stall, r_addr, r_instr},
            {1'b0, 1'b0, 32'h1236, 32'hCAFE_F00D});
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            boot_req      = tbl[i].req;
            byte_valid    = tbl[i].valid;
            byte_data     = tbl[i].data;
            fetch_address = tbl[i].fetch;
            #1;
            chk($sformatf("vec%0d", i),
                {byte_ready, mem_we, fetch_stall, boot_done, mem_address, fetch_instruction},
                {tbl[i].rdy, tbl[i].we, tbl[i].stall, tbl[i].done, tbl[i].addr, tbl[i].instr});
            if (tbl[i].we) chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].wdata);
            @(negedge clk);
        end
        boot_req = 1'b0;
        byte_valid = 1'b0;
        fetch_address = 32'h0;
        chk("img1_mem", {mem[0], mem[1]}, {32'hDEAD_BEEF, 32'h0123_4567});
        chk("img1_writes", wr_cnt, 2);

        // Length one past the counter range is rejected without writing.
        wr0 = wr_cnt;
        start_boot();
        send_word(32'd17, 0, 1'b0);
        #1;
        chk("ovf_err", {boot_err, fetch_stall}, 2'b10);
        chk("ovf_nowrite", wr_cnt, wr0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ovf_sticky", boot_err, 1'b1);
        start_boot();
        #1;
        chk("err_clr", {boot_err, byte_ready}, 2'b01);

        // Largest legal image fills the whole counter range.
        send_word(32'd16, 0, 1'b0);
        for (int i = 0; i < 16; i++) send_word(32'h5A5A_0000 + 32'(i), 0, 1'b0);
        wait_done("n16");
        chk("n16_writes", wr_cnt, wr0 + 16);
        chk("n16_mem", {mem[0], mem[15], mem[16]}, {32'h5A5A_0000, 32'h5A5A_000F, 32'h0});

        // Stalled stream plus a stray boot request in the middle of the load.
        wr0 = wr_cnt;
        start_boot();
        send_word(32'd3, 5, 1'b0);
        send_word(32'h1122_3344, 5, 1'b1);
        send_word(32'h5566_7788, 5, 1'b1);
        send_word(32'h99AA_BBCC, 5, 1'b0);
        wait_done("gap");
        chk("gap_writes", wr_cnt, wr0 + 3);
        chk("gap_mem", {mem[0], mem[1], mem[2]}, {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC});

        // Reset after two words and half of the third.
        start_boot();
        send_word(32'd3, 0, 1'b0);
        send_word(32'hF0F0_0001, 0, 1'b0);
        send_word(32'hF0F0_0002, 0, 1'b0);
        send_byte(8'hEE, 0, 1'b0);
        send_byte(8'hEE, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid", {byte_ready, fetch_stall, boot_err, mem_we, mem_address},
            {1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
        rst_n = 1'b1;
        chk("rst_mid_mem", {mem[0], mem[1], mem[2]}, {32'hF0F0_0001, 32'hF0F0_0002, 32'h99AA_BBCC});
        send_word(32'd1, 0, 1'b0);
        send_word(32'hA55A_3CC3, 0, 1'b0);
        wait_done("reload");
        chk("reload_mem", {mem[0], mem[1]}, {32'hA55A_3CC3, 32'hF0F0_0002});
        fetch_address = 32'h0;
        #1;
        chk("reload_fetch", fetch_instruction, 32'hA55A_3CC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
